// File: rtl/tpu_mem_pkg.sv
// Shared types and width helpers for the operand buffer and its stream controller.
package tpu_mem_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } stream_state_t;

    // Lane index width; kept at least one bit so a single-lane build still has a port.
    function automatic int unsigned calc_lw(input int unsigned lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    function automatic int unsigned calc_ew(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Step counter width: must hold T = depth + lanes - 1.
    function automatic int unsigned calc_tw(input int unsigned depth, input int unsigned lanes);
        return $clog2(depth + lanes);
    endfunction

endpackage

// File: rtl/operand_stream_ctrl.sv
// Stream sequencer: IDLE/STREAM FSM, step counter, latched length/skew, busy/done.
module operand_stream_ctrl
    import tpu_mem_pkg::*;
#(
    parameter int unsigned  LANES = 4,
    parameter int unsigned  DEPTH = 4,
    localparam int unsigned EW    = calc_ew(DEPTH),
    localparam int unsigned TW    = calc_tw(DEPTH, LANES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_start,
    input  logic          i_skew_en,
    input  logic [EW-1:0] i_stream_len,
    input  logic          i_stall,
    output logic          o_busy,
    output logic          o_done,
    output logic [TW-1:0] o_t,
    output logic          o_skew_q,
    output logic [EW-1:0] o_len_q,
    output logic [EW-1:0] o_len_eff_c,
    output logic          o_start_c,
    output logic          o_load_c,
    output logic          o_clear_c
);

    stream_state_t r_state, w_state_nxt;
    logic [TW-1:0] r_t, w_t_nxt;
    logic [TW-1:0] r_tlast, w_tlast_nxt;
    logic [EW-1:0] r_len, w_len_nxt;
    logic          r_skew, w_skew_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_done, w_done_nxt;
    logic [EW-1:0] w_len_eff;

    assign w_len_eff = ((i_stream_len == '0) || (i_stream_len > EW'(DEPTH))) ? EW'(DEPTH)
                                                                              : i_stream_len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_t     <= '0;
            r_tlast <= '0;
            r_len   <= '0;
            r_skew  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_t     <= w_t_nxt;
            r_tlast <= w_tlast_nxt;
            r_len   <= w_len_nxt;
            r_skew  <= w_skew_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_t_nxt     = r_t;
        w_tlast_nxt = r_tlast;
        w_len_nxt   = r_len;
        w_skew_nxt  = r_skew;
        w_done_nxt  = 1'b0;
        o_start_c   = 1'b0;
        o_load_c    = 1'b0;
        o_clear_c   = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_nxt = STREAM;
                    w_t_nxt     = '0;
                    w_len_nxt   = w_len_eff;
                    w_skew_nxt  = i_skew_en;
                    // Stored as T-1 so the last-step test is a plain compare.
                    w_tlast_nxt = TW'(w_len_eff) + (i_skew_en ? TW'(LANES - 1) : TW'(0)) - TW'(1);
                    o_start_c   = 1'b1;
                    o_load_c    = 1'b1;
                end
            end
            STREAM: begin
                if (!i_stall) begin
                    if (r_t == r_tlast) begin
                        w_state_nxt = IDLE;
                        w_t_nxt     = '0;
                        w_done_nxt  = 1'b1;
                        o_clear_c   = 1'b1;
                    end else begin
                        w_t_nxt  = r_t + TW'(1);
                        o_load_c = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        w_busy_nxt = (w_state_nxt == STREAM);
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_t         = r_t;
    assign o_skew_q    = r_skew;
    assign o_len_q     = r_len;
    assign o_len_eff_c = w_len_eff;

endmodule

// File: rtl/operand_buffer.sv
// LANES x DEPTH operand store with combinational manual reads and a skewed,
// registered stream readout for systolic-array edge injection.
module operand_buffer
    import tpu_mem_pkg::*;
#(
    parameter int unsigned  DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned  LANES      = 4,
    parameter int unsigned  DEPTH      = 4,
    localparam int unsigned LW         = calc_lw(LANES),
    localparam int unsigned EW         = calc_ew(DEPTH),
    localparam int unsigned TW         = calc_tw(DEPTH, LANES)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        write_enable,
    input  logic [LW-1:0]               write_line,
    input  logic [EW-1:0]               write_elem,
    input  logic [DATA_WIDTH-1:0]       data_in,
    input  logic [LANES-1:0]            read_enable,
    input  logic [LANES*EW-1:0]         read_elem,
    input  logic                        start,
    input  logic                        skew_en,
    input  logic [EW-1:0]               stream_len,
    input  logic                        stall,
    output logic                        busy,
    output logic                        done,
    output logic [LANES-1:0]            stream_valid,
    output logic [LANES*DATA_WIDTH-1:0] data_out
);

    logic [DATA_WIDTH-1:0]       r_mem [LANES][DEPTH];
    logic [LANES*DATA_WIDTH-1:0] r_data;
    logic [LANES-1:0]            r_valid;

    logic [TW-1:0]               w_t;
    logic                        w_skew_q;
    logic [EW-1:0]               w_len_q;
    logic [EW-1:0]               w_len_eff;
    logic                        w_start;
    logic                        w_load;
    logic                        w_clear;

    logic [TW-1:0]               w_step;
    logic                        w_skew;
    logic [EW-1:0]               w_len;
    logic [LANES*DATA_WIDTH-1:0] w_manual;
    logic [LANES*DATA_WIDTH-1:0] w_stream_data;
    logic [LANES-1:0]            w_stream_valid;

    operand_stream_ctrl #(
        .LANES (LANES),
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (start),
        .i_skew_en    (skew_en),
        .i_stream_len (stream_len),
        .i_stall      (stall),
        .o_busy       (busy),
        .o_done       (done),
        .o_t          (w_t),
        .o_skew_q     (w_skew_q),
        .o_len_q      (w_len_q),
        .o_len_eff_c  (w_len_eff),
        .o_start_c    (w_start),
        .o_load_c     (w_load),
        .o_clear_c    (w_clear)
    );

    // Cell-wise decode drops out-of-range line/elem writes without a range check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < int'(LANES); l++) begin
                for (int e = 0; e < int'(DEPTH); e++) begin
                    r_mem[l][e] <= '0;
                end
            end
        end else if (write_enable) begin
            for (int l = 0; l < int'(LANES); l++) begin
                for (int e = 0; e < int'(DEPTH); e++) begin
                    if ((write_line == LW'(l)) && (write_elem == EW'(e))) begin
                        r_mem[l][e] <= data_in;
                    end
                end
            end
        end
    end

    always_comb begin
        w_manual = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            for (int e = 0; e < int'(DEPTH); e++) begin
                if (read_enable[i] && (read_elem[i*EW +: EW] == EW'(e))) begin
                    w_manual[i*DATA_WIDTH +: DATA_WIDTH] = r_mem[i][e];
                end
            end
        end
    end

    // Step being loaded: step 0 with fresh settings on start, else t+1 with latched ones.
    assign w_step = w_start ? '0        : (w_t + TW'(1));
    assign w_skew = w_start ? skew_en   : w_skew_q;
    assign w_len  = w_start ? w_len_eff : w_len_q;

    always_comb begin
        logic [TW-1:0] w_off;
        w_stream_data  = '0;
        w_stream_valid = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            w_off = w_skew ? TW'(i) : '0;
            for (int e = 0; e < int'(DEPTH); e++) begin
                if ((w_step >= w_off) && ((w_step - w_off) == TW'(e)) && (TW'(e) < TW'(w_len))) begin
                    w_stream_data[i*DATA_WIDTH +: DATA_WIDTH] = r_mem[i][e];
                    w_stream_valid[i]                         = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= '0;
        end else if (w_clear) begin
            r_data  <= '0;
            r_valid <= '0;
        end else if (w_load) begin
            r_data  <= w_stream_data;
            r_valid <= w_stream_valid;
        end
    end

    assign stream_valid = r_valid;
    assign data_out     = busy ? r_data : w_manual;

endmodule

// File: tb/tb_operand_buffer.sv
// Directed self-checking bench for operand_buffer (8-bit data, 4 lanes, depth 4).
module tb_operand_buffer;

    logic        clk;
    logic        rst_n;
    logic        write_enable;
    logic [1:0]  write_line;
    logic [2:0]  write_elem;
    logic [7:0]  data_in;
    logic [3:0]  read_enable;
    logic [11:0] read_elem;
    logic        start;
    logic        skew_en;
    logic [2:0]  stream_len;
    logic        stall;
    logic        busy;
    logic        done;
    logic [3:0]  stream_valid;
    logic [31:0] data_out;

    int n_checks = 0;
    int n_errors = 0;
    int n_busy;

    logic [31:0] skew_data  [7];
    logic [3:0]  skew_valid [7];

    operand_buffer #(
        .DATA_WIDTH (8),
        .LANES      (4),
        .DEPTH      (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .write_enable (write_enable),
        .write_line   (write_line),
        .write_elem   (write_elem),
        .data_in      (data_in),
        .read_enable  (read_enable),
        .read_elem    (read_elem),
        .start        (start),
        .skew_en      (skew_en),
        .stream_len   (stream_len),
        .stall        (stall),
        .busy         (busy),
        .done         (done),
        .stream_valid (stream_valid),
        .data_out     (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] mk_sel(input logic [2:0] e3, input logic [2:0] e2,
                                           input logic [2:0] e1, input logic [2:0] e0);
        return {e3, e2, e1, e0};
    endfunction

    initial begin
        skew_data[0] = 32'h0000_0000; skew_valid[0] = 4'b0001;
        skew_data[1] = 32'h0000_1001; skew_valid[1] = 4'b0011;
        skew_data[2] = 32'h0020_1102; skew_valid[2] = 4'b0111;
        skew_data[3] = 32'h3021_1203; skew_valid[3] = 4'b1111;
        skew_data[4] = 32'h3122_1300; skew_valid[4] = 4'b1110;
        skew_data[5] = 32'h3223_0000; skew_valid[5] = 4'b1100;
        skew_data[6] = 32'h3300_0000; skew_valid[6] = 4'b1000;

        rst_n = 1'b0; write_enable = 1'b0; write_line = '0; write_elem = '0; data_in = '0;
        read_enable = 4'b1111; read_elem = mk_sel(3'd1, 3'd1, 3'd1, 3'd1);
        start = 1'b0; skew_en = 1'b0; stream_len = '0; stall = 1'b0;
        #2;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_valid", 32'(stream_valid), 32'd0);
        check_eq("rst_data", data_out, 32'h0);
        #1 rst_n = 1'b1;

        // Preload mem[l][e] = 16*l + e, plus one out-of-range element write.
        for (int l = 0; l < 4; l++) begin
            for (int e = 0; e < 4; e++) begin
                write_enable = 1'b1; write_line = 2'(l); write_elem = 3'(e);
                data_in = 8'(16 * l + e);
                step();
            end
        end
        write_line = 2'd1; write_elem = 3'd4; data_in = 8'hFF;
        step();
        write_enable = 1'b0;

        // Manual read.
        read_enable = 4'b1011; read_elem = mk_sel(3'd0, 3'd1, 3'd2, 3'd3);
        #1 check_eq("manual_mix", data_out, 32'h3000_1203);
        check_eq("manual_valid", 32'(stream_valid), 32'd0);
        read_enable = 4'b1111; read_elem = mk_sel(3'd3, 3'd4, 3'd3, 3'd7);
        #1 check_eq("manual_oor", data_out, 32'h3300_1300);
        read_enable = 4'b0000;

        // Skewed full stream; mid-stream start/skew/len changes are ignored.
        start = 1'b1; skew_en = 1'b1; stream_len = 3'd0;
        step();
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            check_eq($sformatf("skew_busy%0d", k), 32'(busy), 32'd1);
            check_eq($sformatf("skew_valid%0d", k), 32'(stream_valid), 32'(skew_valid[k]));
            check_eq($sformatf("skew_data%0d", k), data_out, skew_data[k]);
            start      = (k == 2);
            skew_en    = (k != 2);
            stream_len = (k == 2) ? 3'd1 : 3'd0;
            step();
        end
        start = 1'b0;
        check_eq("skew_done", 32'(done), 32'd1);
        check_eq("skew_done_busy", 32'(busy), 32'd0);
        check_eq("skew_done_valid", 32'(stream_valid), 32'd0);
        step();
        check_eq("skew_done_pulse", 32'(done), 32'd0);
        check_eq("skew_idle_busy", 32'(busy), 32'd0);

        // Aligned short stream, then back-to-back start in the done cycle.
        start = 1'b1; skew_en = 1'b0; stream_len = 3'd2;
        step();
        start = 1'b0;
        check_eq("al_data0", data_out, 32'h3020_1000);
        check_eq("al_valid0", 32'(stream_valid), 32'hF);
        step();
        check_eq("al_data1", data_out, 32'h3121_1101);
        step();
        check_eq("al_done", 32'(done), 32'd1);
        check_eq("al_busy", 32'(busy), 32'd0);
        start = 1'b1; stream_len = 3'd1;
        step();
        start = 1'b0;
        check_eq("b2b_busy", 32'(busy), 32'd1);
        check_eq("b2b_done", 32'(done), 32'd0);
        check_eq("b2b_data", data_out, 32'h3020_1000);
        step();
        check_eq("b2b_end_done", 32'(done), 32'd1);
        stall = 1'b1;
        step();
        check_eq("done_stall", 32'(done), 32'd0);
        check_eq("done_stall_busy", 32'(busy), 32'd0);
        stall = 1'b0;

        // Skewed stream with a same-edge write and a 3-clock stall at step 2.
        n_busy = 0;
        start = 1'b1; skew_en = 1'b1; stream_len = 3'd4;
        step();
        start = 1'b0;
        if (busy) n_busy++;
        check_eq("st_data0", data_out, skew_data[0]);
        step();
        if (busy) n_busy++;
        write_enable = 1'b1; write_line = 2'd2; write_elem = 3'd0; data_in = 8'hAA;
        step();
        write_enable = 1'b0;
        if (busy) n_busy++;
        check_eq("st_old_data", data_out, skew_data[2]);
        stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            step();
            if (busy) n_busy++;
            check_eq($sformatf("st_frz_data%0d", s), data_out, skew_data[2]);
            check_eq($sformatf("st_frz_valid%0d", s), 32'(stream_valid), 32'(skew_valid[2]));
        end
        stall = 1'b0;
        for (int k = 3; k < 7; k++) begin
            step();
            if (busy) n_busy++;
            check_eq($sformatf("st_data%0d", k), data_out, skew_data[k]);
        end
        step();
        check_eq("st_done", 32'(done), 32'd1);
        check_eq("st_cycles", 32'(n_busy), 32'd10);
        read_enable = 4'b0100; read_elem = mk_sel(3'd0, 3'd0, 3'd0, 3'd0);
        #1 check_eq("st_new_cell", data_out, 32'h00AA_0000);
        read_enable = 4'b0000;

        // Reset in the middle of a stream.
        start = 1'b1; skew_en = 1'b1; stream_len = 3'd0;
        step();
        start = 1'b0;
        repeat (4) step();
        check_eq("rm_data4", data_out, skew_data[4]);
        rst_n = 1'b0;
        #1;
        check_eq("rm_busy", 32'(busy), 32'd0);
        check_eq("rm_valid", 32'(stream_valid), 32'd0);
        check_eq("rm_done", 32'(done), 32'd0);
        #2 rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            check_eq($sformatf("rm_nodone%0d", c), 32'(done), 32'd0);
            check_eq($sformatf("rm_idle%0d", c), 32'(busy), 32'd0);
        end
        read_enable = 4'b0010; read_elem = mk_sel(3'd0, 3'd0, 3'd1, 3'd0);
        #1 check_eq("rm_cleared", data_out, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
